// File: rtl/matrix_calc_core.sv
// matrix_calc_core: serial-load DIM x DIM signed matrix calculator (A*B, A+B, A-B), one result shown at a time.
// Define MATRIX_CALC_TRANSPOSE_EN to turn op 01 into transpose(A) instead of an error.
module matrix_calc_core #(
  parameter int DIM = 2,
  parameter int W   = 4,
  localparam int OW = 2*W + $clog2(DIM),
  localparam int IW = $clog2(DIM*DIM)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  data_in,
  input  logic          enter,
  input  logic          next,
  input  logic [1:0]    op,
  output logic [OW-1:0] data_out,
  output logic [IW-1:0] index,
  output logic          busy,
  output logic          finish,
  output logic          error
);
  localparam int N    = DIM*DIM;
  localparam int CNTW = $clog2(2*N);
  localparam int CW   = $clog2(DIM);

  typedef enum logic [2:0] {
    S_LOAD  = 3'd0,
    S_CHECK = 3'd1,
    S_CALC  = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t               state_r;
  logic                 enter_q_r, next_q_r;
  logic                 enter_pulse_s, next_pulse_s;
  logic [CNTW-1:0]      cnt_r;
  logic [IW-1:0]        index_r;
  logic [1:0]           op_r;
  logic [CW-1:0]        i_r, j_r, k_r;
  logic signed [OW-1:0] acc_r;
  logic signed [W-1:0]  mem_r [0:2*N-1];
  logic signed [OW-1:0] result_r [0:N-1];
  logic signed [OW-1:0] data_out_r;
  logic                 busy_r, finish_r, error_r;

  logic [CNTW-1:0]      a_idx_s, b_idx_s;
  logic [IW-1:0]        res_idx_s, index_nxt_s;
  logic signed [OW-1:0] a_ext_s, b_ext_s, mac_s, elem_s;
  logic                 is_mul_s, last_i_s, last_j_s, last_k_s, calc_last_s;

  // Button/switch edge detection history
  always_ff @(posedge clk) begin
    if (rst) begin
      enter_q_r <= 1'b0;
      next_q_r  <= 1'b0;
    end else begin
      enter_q_r <= enter;
      next_q_r  <= next;
    end
  end

  assign enter_pulse_s = enter & ~enter_q_r;
  assign next_pulse_s  = next & ~next_q_r;

  // Operand selection and arithmetic for the current loop position
  always_comb begin
    is_mul_s    = (op_r == 2'b00);
    last_i_s    = (i_r == CW'(DIM-1));
    last_j_s    = (j_r == CW'(DIM-1));
    last_k_s    = (k_r == CW'(DIM-1));
    calc_last_s = last_i_s && last_j_s && (last_k_s || !is_mul_s);
    res_idx_s   = IW'(int'(i_r)*DIM + int'(j_r));
    index_nxt_s = (index_r == IW'(N-1)) ? {IW{1'b0}} : index_r + IW'(1);
    if (is_mul_s) begin
      a_idx_s = CNTW'(int'(i_r)*DIM + int'(k_r));
      b_idx_s = CNTW'(N + int'(k_r)*DIM + int'(j_r));
    end else if (op_r == 2'b01) begin
      a_idx_s = CNTW'(int'(j_r)*DIM + int'(i_r));
      b_idx_s = CNTW'(N);
    end else begin
      a_idx_s = CNTW'(int'(i_r)*DIM + int'(j_r));
      b_idx_s = CNTW'(N + int'(i_r)*DIM + int'(j_r));
    end
    a_ext_s = OW'(mem_r[a_idx_s]);
    b_ext_s = OW'(mem_r[b_idx_s]);
    // k = 0 starts a fresh dot product, so the stale accumulator is dropped
    mac_s   = ((k_r == {CW{1'b0}}) ? {OW{1'b0}} : acc_r) + a_ext_s * b_ext_s;
    case (op_r)
      2'b10:   elem_s = a_ext_s + b_ext_s;
      2'b11:   elem_s = a_ext_s - b_ext_s;
      2'b01:   elem_s = a_ext_s;
      default: elem_s = mac_s;
    endcase
  end

  // Main control FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_LOAD;
      cnt_r      <= {CNTW{1'b0}};
      index_r    <= {IW{1'b0}};
      op_r       <= 2'b00;
      i_r        <= {CW{1'b0}};
      j_r        <= {CW{1'b0}};
      k_r        <= {CW{1'b0}};
      acc_r      <= {OW{1'b0}};
      data_out_r <= {OW{1'b0}};
      busy_r     <= 1'b0;
      finish_r   <= 1'b0;
      error_r    <= 1'b0;
      for (int n = 0; n < N; n++) result_r[n] <= {OW{1'b0}};
    end else begin
      case (state_r)
        S_LOAD: begin
          if (enter_pulse_s) begin
            mem_r[cnt_r] <= data_in;
            if (cnt_r == CNTW'(2*N-1)) begin
              op_r    <= op;
              cnt_r   <= {CNTW{1'b0}};
              busy_r  <= 1'b1;
              state_r <= S_CHECK;
            end else begin
              cnt_r <= cnt_r + CNTW'(1);
            end
          end
        end
        S_CHECK: begin
          i_r   <= {CW{1'b0}};
          j_r   <= {CW{1'b0}};
          k_r   <= {CW{1'b0}};
          acc_r <= {OW{1'b0}};
`ifdef MATRIX_CALC_TRANSPOSE_EN
          state_r <= S_CALC;
`else
          if (op_r == 2'b01) begin
            busy_r  <= 1'b0;
            error_r <= 1'b1;
            state_r <= S_ERR;
          end else begin
            state_r <= S_CALC;
          end
`endif
        end
        S_CALC: begin
          acc_r <= mac_s;
          if (!is_mul_s || last_k_s) result_r[res_idx_s] <= elem_s;
          if (is_mul_s && !last_k_s) begin
            k_r <= k_r + CW'(1);
          end else begin
            k_r <= {CW{1'b0}};
            if (!last_j_s) begin
              j_r <= j_r + CW'(1);
            end else begin
              j_r <= {CW{1'b0}};
              i_r <= last_i_s ? {CW{1'b0}} : i_r + CW'(1);
            end
          end
          // index is 0 here and slot 0 is never the final write, so it is already valid
          if (calc_last_s) begin
            busy_r     <= 1'b0;
            finish_r   <= 1'b1;
            data_out_r <= result_r[index_r];
            state_r    <= S_DONE;
          end
        end
        S_DONE, S_ERR: begin
          if (enter_pulse_s) begin
            state_r    <= S_LOAD;
            cnt_r      <= {CNTW{1'b0}};
            index_r    <= {IW{1'b0}};
            data_out_r <= {OW{1'b0}};
            finish_r   <= 1'b0;
            error_r    <= 1'b0;
            for (int n = 0; n < N; n++) result_r[n] <= {OW{1'b0}};
          end else if (next_pulse_s && state_r == S_DONE) begin
            index_r    <= index_nxt_s;
            data_out_r <= result_r[index_nxt_s];
          end
        end
        default: begin
          state_r    <= S_LOAD;
          cnt_r      <= {CNTW{1'b0}};
          index_r    <= {IW{1'b0}};
          data_out_r <= {OW{1'b0}};
          busy_r     <= 1'b0;
          finish_r   <= 1'b0;
          error_r    <= 1'b0;
        end
      endcase
    end
  end

  assign data_out = data_out_r;
  assign index    = index_r;
  assign busy     = busy_r;
  assign finish   = finish_r;
  assign error    = error_r;
endmodule

// File: tb/tb_matrix_calc_core.sv
// Self-checking bench for matrix_calc_core (DIM=2, W=4): spec vector table, hand-written corner
// sequences and randomized runs against a plain-arithmetic matrix model.
module tb_matrix_calc_core;
  localparam int D  = 2;
  localparam int N  = D*D;
  localparam int OW = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    data_in;
  logic          enter, next;
  logic [1:0]    op;
  logic [OW-1:0] data_out;
  logic [1:0]    index;
  logic          busy, finish, error;

  int pass_cnt = 0;
  int total_cnt = 0;

  matrix_calc_core #(.DIM(2), .W(4)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .enter(enter), .next(next), .op(op),
    .data_out(data_out), .index(index), .busy(busy), .finish(finish), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0][3:0]    m;    // A elements 0..3 then B elements 0..3, row-major
    logic [1:0]         opv;
    logic [3:0][OW-1:0] ex;
    logic [7:0]         k;
  } vec_t;

  vec_t tbl [6];
  int   nv;

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic press_enter(input logic [3:0] v);
    @(negedge clk); data_in = v; enter = 1'b1;
    @(negedge clk); enter = 1'b0;
  endtask

  task automatic press_next();
    @(negedge clk); next = 1'b1;
    @(negedge clk); next = 1'b0;
  endtask

  // Loads all 8 elements; op holds the reserved code until the last press
  task automatic load_mats(input logic [7:0][3:0] m, input logic [1:0] opv);
    for (int e = 0; e < 2*N; e++) begin
      op = (e == 2*N-1) ? opv : 2'b01;
      press_enter(m[e]);
    end
  endtask

  // Counts edges after the capture edge until the flag rises (bounded)
  task automatic wait_flag(input bit want_err, output int m);
    m = 0;
    while (!(want_err ? error : finish) && m < 60) begin
      @(negedge clk); m++;
    end
  endtask

  task automatic readout(input logic [3:0][OW-1:0] ex, input string tag);
    chk({tag, " idx0"}, int'(index), 0);
    chk({tag, " out0"}, int'($signed(data_out)), int'($signed(ex[0])));
    for (int e = 1; e < N; e++) begin
      press_next();
      chk({tag, " idx"}, int'(index), e);
      chk({tag, " out"}, int'($signed(data_out)), int'($signed(ex[e])));
    end
    press_next();
    chk({tag, " wrap"}, int'(index), 0);
  endtask

  task automatic leave(input string tag);
    press_enter(4'd7);
    chk({tag, " leave finish"}, int'(finish), 0);
    chk({tag, " leave out"}, int'(data_out), 0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int m;
    load_mats(v.m, v.opv);
    chk({tag, " busy"}, int'(busy), 1);
    wait_flag(1'b0, m);
    chk({tag, " latency"}, m, int'(v.k) + 1);
    readout(v.ex, tag);
    leave(tag);
  endtask

  // Reference model: textbook matrix arithmetic on signed element values
  function automatic int model(input logic [7:0][3:0] m, input logic [1:0] o, input int e);
    int i, j, s;
    i = e / D; j = e % D; s = 0;
    case (o)
      2'b00: for (int k = 0; k < D; k++)
               s += int'($signed(m[i*D+k])) * int'($signed(m[N+k*D+j]));
      2'b10: s = int'($signed(m[e])) + int'($signed(m[N+e]));
      2'b11: s = int'($signed(m[e])) - int'($signed(m[N+e]));
      default: s = int'($signed(m[j*D+i]));
    endcase
    return s;
  endfunction

  localparam logic [7:0][3:0] MAB = {4'(-1), 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};
  localparam logic [7:0][3:0] M8  = {8{4'(-8)}};

  initial begin
    int m;
    vec_t rv;
    rst = 1'b1; enter = 1'b0; next = 1'b0; op = 2'b00; data_in = 4'd0;
    tbl[0] = '{m: MAB, opv: 2'b00, ex: {9'd14, 9'd43, 9'd4, 9'd19}, k: 8'd8};
    tbl[1] = '{m: MAB, opv: 2'b10, ex: {9'd3, 9'd10, 9'd8, 9'd6}, k: 8'd4};
    tbl[2] = '{m: MAB, opv: 2'b11, ex: {9'd5, 9'(-4), 9'(-4), 9'(-4)}, k: 8'd4};
    tbl[3] = '{m: M8, opv: 2'b00, ex: {4{9'd128}}, k: 8'd8};
    tbl[4] = '{m: M8, opv: 2'b11, ex: {4{9'd0}}, k: 8'd4};
    nv = 5;
`ifdef MATRIX_CALC_TRANSPOSE_EN
    tbl[5] = '{m: MAB, opv: 2'b01, ex: {9'd4, 9'd2, 9'd3, 9'd1}, k: 8'd4};
    nv = 6;
`endif
    repeat (3) @(negedge clk);
    chk("reset out", int'(data_out), 0);
    chk("reset flags", int'({busy, finish, error}), 0);
    chk("reset index", int'(index), 0);
    rst = 1'b0;

    for (int t = 0; t < nv; t++) run_vec(tbl[t], $sformatf("vec%0d", t));

`ifndef MATRIX_CALC_TRANSPOSE_EN
    load_mats(MAB, 2'b01);
    wait_flag(1'b1, m);
    chk("err latency", m, 1);
    chk("err out", int'(data_out), 0);
    chk("err flags", int'({busy, finish}), 0);
    press_next();
    chk("err next ignored", int'(index), 0);
    chk("err held", int'(error), 1);
    press_enter(4'd3);
    chk("err cleared", int'(error), 0);
    run_vec(tbl[0], "after err");
`endif

    // Held next gives a single advance; simultaneous enter+next returns to LOAD
    load_mats(MAB, 2'b10);
    wait_flag(1'b0, m);
    @(negedge clk); next = 1'b1;
    repeat (5) @(negedge clk);
    chk("held next idx", int'(index), 1);
    chk("held next out", int'($signed(data_out)), 8);
    next = 1'b0;
    @(negedge clk); next = 1'b1; enter = 1'b1;
    @(negedge clk); next = 1'b0; enter = 1'b0;
    chk("enter wins finish", int'(finish), 0);
    chk("enter wins idx", int'(index), 0);
    run_vec(tbl[0], "after both");

    // Reset during multiply at E0+4
    load_mats(MAB, 2'b00);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("midrst flags", int'({busy, finish, error}), 0);
    chk("midrst out", int'(data_out), 0);
    run_vec(tbl[0], "after rst");

    // Enter during CALC is not captured
    load_mats(MAB, 2'b00);
    press_enter(4'd7);
    wait_flag(1'b0, m);
    chk("calc enter latency", m, 7);
    readout(tbl[0].ex, "calc enter");
    leave("calc enter");
    run_vec(tbl[1], "after calc enter");

    // Randomized runs against the model
    for (int r = 0; r < 20; r++) begin
      for (int e = 0; e < 2*N; e++) rv.m[e] = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 2))
        0: rv.opv = 2'b00;
        1: rv.opv = 2'b10;
        default: rv.opv = 2'b11;
      endcase
      for (int e = 0; e < N; e++) rv.ex[e] = OW'(model(rv.m, rv.opv, e));
      rv.k = (rv.opv == 2'b00) ? 8'd8 : 8'd4;
      run_vec(rv, $sformatf("rand%0d", r));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
